addsub_serial: RTL and testbench

//   Parametrised, multi-cycle two's-complement add/subtract unit for the ALU datapath.

---
 rtl/addsub_pkg.sv | 17 +
 rtl/addsub_chunk.sv | 17 +
 rtl/addsub_serial.sv | 124 ++++++++++++
 tb/tb_addsub_serial.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared constants, FSM state type and sizing helper for the chunk-serial add/subtract unit.
package addsub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
      return width / chunk;
   endfunction

endpackage

// File: rtl/addsub_chunk.sv
// One CHUNK-bit adder slice; c_msb is the carry into the slice MSB, used for signed overflow.
module addsub_chunk #(
   parameter int unsigned CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
   // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out of the XOR.
   assign c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/addsub_serial.sv
// Chunk-serial two's-complement ADD/SUB with carry/overflow/zero flags and valid/ready handshakes.
// Optional saturation (extra in_sat port) is enabled by defining ADDSUB_SATURATE_EN.
module addsub_serial
   import addsub_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_op,
`ifdef ADDSUB_SATURATE_EN
   input  logic             in_sat,
`endif
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);

   localparam int unsigned   N    = nchunk(WIDTH, CHUNK);
   localparam int unsigned   CW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("addsub_serial: WIDTH must be a multiple of CHUNK");
   end

   state_t           state, next_state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] a_reg, b_reg, res_next;
   logic             run_c;
   logic [CHUNK-1:0] sl_a, sl_b, sl_sum;
   logic             sl_cout, sl_cmsb;
`ifdef ADDSUB_SATURATE_EN
   logic             sat_reg;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (in_valid)        next_state = ST_RUN;
         ST_RUN:  if (count == LAST)   next_state = ST_DONE;
         ST_DONE: if (out_ready)       next_state = ST_IDLE;
         default:                      next_state = ST_IDLE;
      endcase
   end

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);

   assign sl_a = a_reg[count*CHUNK +: CHUNK];
   assign sl_b = b_reg[count*CHUNK +: CHUNK];

   addsub_chunk #(.CHUNK(CHUNK)) u_slice (
      .a     (sl_a),
      .b     (sl_b),
      .cin   (run_c),
      .sum   (sl_sum),
      .cout  (sl_cout),
      .c_msb (sl_cmsb)
   );

   always_comb begin
      res_next = result;
      res_next[count*CHUNK +: CHUNK] = sl_sum;
`ifdef ADDSUB_SATURATE_EN
      // On overflow the raw MSB has the wrong sign: raw 1 means the true result was positive.
      if (count == LAST && sat_reg && (sl_cout ^ sl_cmsb))
         res_next = res_next[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg    <= '0;
         b_reg    <= '0;
         run_c    <= 1'b0;
         count    <= '0;
         result   <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
`ifdef ADDSUB_SATURATE_EN
         sat_reg  <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: if (in_valid) begin
               a_reg   <= in_a;
               b_reg   <= in_b ^ {WIDTH{in_op == OP_SUB}};
               run_c   <= (in_op == OP_SUB);
               count   <= '0;
`ifdef ADDSUB_SATURATE_EN
               sat_reg <= in_sat;
`endif
            end
            ST_RUN: begin
               result <= res_next;
               run_c  <= sl_cout;
               count  <= count + 1'b1;
               if (count == LAST) begin
                  carry    <= sl_cout;
                  overflow <= sl_cout ^ sl_cmsb;
                  zero     <= (res_next == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial: three instances (CHUNK 8, 32, 1) driven one transaction at a time.
module tb_addsub_serial;

   localparam int unsigned W = 32;

   typedef struct {
      logic [W-1:0] res;
      logic         c;
      logic         v;
      logic         z;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic [2:0]       in_valid, out_ready, in_ready, out_valid, carry, overflow, zero;
   logic             in_op;
   logic [W-1:0]     in_a, in_b;
   logic [W-1:0]     result [3];
`ifdef ADDSUB_SATURATE_EN
   logic             in_sat;
`endif

   exp_t        sb[$];
   int unsigned total  = 0;
   int unsigned passed = 0;
   int unsigned nch [3] = '{4, 1, 32};

   addsub_serial #(.WIDTH(W), .CHUNK(8)) u_c8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_op(in_op),
`ifdef ADDSUB_SATURATE_EN
      .in_sat(in_sat),
`endif
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .result(result[0]), .carry(carry[0]), .overflow(overflow[0]), .zero(zero[0])
   );

   addsub_serial #(.WIDTH(W), .CHUNK(32)) u_c32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_op(in_op),
`ifdef ADDSUB_SATURATE_EN
      .in_sat(in_sat),
`endif
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .result(result[1]), .carry(carry[1]), .overflow(overflow[1]), .zero(zero[1])
   );

   addsub_serial #(.WIDTH(W), .CHUNK(1)) u_c1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_op(in_op),
`ifdef ADDSUB_SATURATE_EN
      .in_sat(in_sat),
`endif
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .result(result[2]), .carry(carry[2]), .overflow(overflow[2]), .zero(zero[2])
   );

   function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sat);
      exp_t         e;
      logic [W:0]   full;
      logic [W-1:0] bx;
      bx    = op ? ~b : b;
      full  = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, op};
      e.res = full[W-1:0];
      e.c   = full[W];
      e.v   = (a[W-1] == bx[W-1]) && (e.res[W-1] != a[W-1]);
      if (sat && e.v)
         e.res = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      e.z   = (e.res == '0);
      return e;
   endfunction

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
   endtask

   function automatic string nm(input int idx, input string s);
      return $sformatf("u%0d_%s", idx, s);
   endfunction

   task automatic start_op(input int idx, input logic op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic sat);
      int unsigned k;
      logic        sat_eff;
      @(negedge clk);
      k = 0;
      while (!in_ready[idx] && k < 50) begin
         @(negedge clk);
         k++;
      end
      check(nm(idx, "in_ready_before_issue"), {31'd0, in_ready[idx]}, 32'd1);
`ifdef ADDSUB_SATURATE_EN
      in_sat  = sat;
      sat_eff = sat;
`else
      sat_eff = 1'b0 & sat;
`endif
      in_a = a;
      in_b = b;
      in_op = op;
      in_valid[idx] = 1'b1;
      @(posedge clk);
      sb.push_back(model(op, a, b, sat_eff));
      #1 in_valid[idx] = 1'b0;
   endtask

   task automatic wait_result(input int idx);
      int unsigned cyc;
      exp_t        e;
      cyc = 0;
      while (!out_valid[idx] && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check(nm(idx, "latency"), cyc, nch[idx]);
      if (sb.size() == 0) begin
         check(nm(idx, "scoreboard_nonempty"), 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check(nm(idx, "result"),   result[idx], e.res);
         check(nm(idx, "carry"),    {31'd0, carry[idx]},    {31'd0, e.c});
         check(nm(idx, "overflow"), {31'd0, overflow[idx]}, {31'd0, e.v});
         check(nm(idx, "zero"),     {31'd0, zero[idx]},     {31'd0, e.z});
      end
   endtask

   task automatic finish_op(input int idx);
      out_ready[idx] = 1'b1;
      @(posedge clk);
      #1 out_ready[idx] = 1'b0;
      check(nm(idx, "out_valid_after_take"), {31'd0, out_valid[idx]}, 32'd0);
      check(nm(idx, "in_ready_after_take"),  {31'd0, in_ready[idx]},  32'd1);
   endtask

   task automatic do_op(input int idx, input logic op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic sat);
      start_op(idx, op, a, b, sat);
      wait_result(idx);
      finish_op(idx);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t held;
      in_valid  = '0;
      out_ready = '0;
      in_op     = 1'b0;
      in_a      = '0;
      in_b      = '0;
`ifdef ADDSUB_SATURATE_EN
      in_sat    = 1'b0;
`endif
      rst_n     = 1'b0;
      #12;
      for (int i = 0; i < 3; i++) begin
         check(nm(i, "rst_result"),    result[i], 32'd0);
         check(nm(i, "rst_carry"),     {31'd0, carry[i]},     32'd0);
         check(nm(i, "rst_overflow"),  {31'd0, overflow[i]},  32'd0);
         check(nm(i, "rst_zero"),      {31'd0, zero[i]},      32'd0);
         check(nm(i, "rst_out_valid"), {31'd0, out_valid[i]}, 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 3; i++)
         check(nm(i, "rst_in_ready"), {31'd0, in_ready[i]}, 32'd1);

      // Directed vectors 1-3 on every chunking
      for (int i = 0; i < 3; i++) begin
         do_op(i, 1'b0, 32'h0000_0005, 32'h0000_0003, 1'b0);
         do_op(i, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0);
`ifdef ADDSUB_SATURATE_EN
         do_op(i, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1);
         do_op(i, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
`endif
         do_op(i, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0);
         do_op(i, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
         do_op(i, 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0);
         do_op(i, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
         for (int r = 0; r < 4; r++)
            do_op(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
      end

      // Backpressure in DONE with a competing request pending
      held = model(1'b0, 32'h1111_1111, 32'h2222_2222, 1'b0);
      start_op(0, 1'b0, 32'h1111_1111, 32'h2222_2222, 1'b0);
      wait_result(0);
      in_a = 32'hDEAD_BEEF;
      in_b = 32'h0BAD_F00D;
      in_op = 1'b1;
      in_valid[0] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check(nm(0, "bp_result"),    result[0], held.res);
         check(nm(0, "bp_out_valid"), {31'd0, out_valid[0]}, 32'd1);
         check(nm(0, "bp_in_ready"),  {31'd0, in_ready[0]},  32'd0);
      end
      out_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[0] = 1'b0;
      in_valid[0]  = 1'b0;
      check(nm(0, "bp_release_in_ready"),  {31'd0, in_ready[0]},  32'd1);
      check(nm(0, "bp_release_out_valid"), {31'd0, out_valid[0]}, 32'd0);
      @(posedge clk);
      #1;
      check(nm(0, "bp_no_reaccept"), {31'd0, in_ready[0]}, 32'd1);

      // Reset during the second RUN cycle discards the operation
      start_op(0, 1'b0, 32'h0F0F_0F0F, 32'h0000_0001, 1'b0);
      void'(sb.pop_back());
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check(nm(0, "abort_out_valid"), {31'd0, out_valid[0]}, 32'd0);
      check(nm(0, "abort_result"),    result[0], 32'd0);
      #3 rst_n = 1'b1;
      #1;
      check(nm(0, "abort_in_ready"),  {31'd0, in_ready[0]}, 32'd1);
      do_op(0, 1'b0, 32'd7, 32'd9, 1'b0);
      check(nm(0, "fresh_add_result"), result[0], 32'h0000_0010);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
